// File: rtl/current_sense_sequencer.sv
// current_sense_sequencer: periodic read of a current sensor through an SPI master,
// with frame validation, 13-bit signed current output and sticky error reporting.
// Ports:
//   CLK, reset (async, active high)  enable, err_clr        : control
//   wren_o / wr_ack_i                                        : SPI write handshake
//   do_valid_i, do_i[15:0]                                   : SPI received word
//   current[12:0] signed, current_valid, overcurrent         : sample outputs
//   status_err, timeout_err, err_count[7:0], busy            : status outputs
module current_sense_sequencer #(
   parameter int unsigned PERIOD  = 64000,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               enable,
   input  logic               err_clr,
   output logic               wren_o,
   input  logic               wr_ack_i,
   input  logic               do_valid_i,
   input  logic [15:0]        do_i,
   output logic signed [12:0] current,
   output logic               current_valid,
   output logic               overcurrent,
   output logic               status_err,
   output logic               timeout_err,
   output logic [7:0]         err_count,
   output logic               busy
);

   localparam int unsigned PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
   localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [PW-1:0] P_LOAD = PW'(PERIOD - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      CHECK
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [PW-1:0] pcnt;
   logic [TW-1:0] tcnt;
   logic [15:0]   word;
   logic          expire;
   logic          tmo;
   logic          frame_ok;
   logic          frame_bad;
   logic          err_ev;

   // tcnt counts cycles already spent in REQ/WAIT; the last allowed
   // cycle is the one where it reaches TIMEOUT-1.
   assign expire    = (tcnt == T_LAST);
   assign frame_ok  = ~word[15] & ~(^word);
   assign frame_bad = (state == CHECK) & ~frame_ok;
   assign err_ev    = tmo | frame_bad;

   assign wren_o = (state == REQ);
   assign busy   = (state != IDLE);

   always_comb begin
      state_nx = state;
      tmo      = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable && (pcnt == '0))
               state_nx = REQ;
         end
         REQ: begin
            // The event is tested first so it wins over expiry.
            if (wr_ack_i) begin
               state_nx = WAIT;
            end else if (expire) begin
               state_nx = IDLE;
               tmo      = 1'b1;
            end
         end
         WAIT: begin
            if (do_valid_i) begin
               state_nx = CHECK;
            end else if (expire) begin
               state_nx = IDLE;
               tmo      = 1'b1;
            end
         end
         CHECK: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Period counter restarts at each request start so starts are
   // spaced PERIOD cycles apart; it parks at 0 once expired.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         pcnt <= '0;
         tcnt <= '0;
      end else begin
         if ((state == IDLE) && (state_nx == REQ))
            pcnt <= P_LOAD;
         else if (pcnt != '0)
            pcnt <= pcnt - PW'(1);

         if (state_nx != state)
            tcnt <= '0;
         else if ((state == REQ) || (state == WAIT))
            tcnt <= tcnt + TW'(1);
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset)
         word <= '0;
      else if ((state == WAIT) && do_valid_i)
         word <= do_i;
   end

   // Raw 0..8191 maps onto -4096..+4095 by subtracting the midpoint.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         current       <= '0;
         overcurrent   <= 1'b0;
         current_valid <= 1'b0;
      end else begin
         current_valid <= 1'b0;
         if ((state == CHECK) && frame_ok) begin
            current       <= $signed(word[12:0] - 13'd4096);
            overcurrent   <= word[13];
            current_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         err_count   <= '0;
         status_err  <= 1'b0;
         timeout_err <= 1'b0;
      end else if (err_clr) begin
         err_count   <= '0;
         status_err  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (tmo)
            timeout_err <= 1'b1;
         if (frame_bad)
            status_err <= 1'b1;
         if (err_ev && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_current_sense_sequencer.sv
// tb_current_sense_sequencer: scenario tasks plus randomized frames checked
// against a behavioural model of the sequencer (PERIOD=100, TIMEOUT=50).
module tb_current_sense_sequencer;

   localparam int PERIOD  = 100;
   localparam int TIMEOUT = 50;

   logic               CLK = 1'b0;
   logic               reset = 1'b0;
   logic               enable = 1'b0;
   logic               err_clr = 1'b0;
   logic               wr_ack_i = 1'b0;
   logic               do_valid_i = 1'b0;
   logic [15:0]        do_i = '0;
   logic               wren_o;
   logic signed [12:0] current;
   logic               current_valid;
   logic               overcurrent;
   logic               status_err;
   logic               timeout_err;
   logic [7:0]         err_count;
   logic               busy;

   current_sense_sequencer #(
      .PERIOD (PERIOD),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK          (CLK),
      .reset        (reset),
      .enable       (enable),
      .err_clr      (err_clr),
      .wren_o       (wren_o),
      .wr_ack_i     (wr_ack_i),
      .do_valid_i   (do_valid_i),
      .do_i         (do_i),
      .current      (current),
      .current_valid(current_valid),
      .overcurrent  (overcurrent),
      .status_err   (status_err),
      .timeout_err  (timeout_err),
      .err_count    (err_count),
      .busy         (busy)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   // behavioural model state
   int m_cur = 0;
   bit m_oc = 0;
   bit m_st = 0;
   bit m_to = 0;
   int m_err = 0;

   // driver observations
   bit d_ok;
   bit d_drop;
   bit d_b50;
   bit d_b51;
   int d_pulses;
   int d_lat;
   int d_start;

   function automatic void m_bump();
      m_err = (m_err >= 255) ? 255 : m_err + 1;
   endfunction

   function automatic bit good(input logic [15:0] w);
      return !w[15] && ($countones(w) % 2 == 0);
   endfunction

   function automatic void m_frame(input logic [15:0] w);
      if (!good(w)) begin
         m_st = 1;
         m_bump();
      end else begin
         m_cur = int'(w[12:0]) - 4096;
         m_oc  = w[13];
      end
   endfunction

   function automatic void m_clear();
      m_err = 0;
      m_st  = 0;
      m_to  = 0;
   endfunction

   // ack_dly < 0: never ack; data_dly <= 0: never send data
   task automatic txn(input int ack_dly, input int data_dly,
                      input logic [15:0] w);
      int n = 0;
      d_ok = 0; d_drop = 0; d_b50 = 0; d_b51 = 0;
      d_pulses = 0; d_lat = -1;
      while (!wren_o && n < 3 * PERIOD) begin
         @(negedge CLK);
         n++;
      end
      if (!wren_o) return;
      d_start = cyc;
      if (ack_dly < 0) begin
         repeat (TIMEOUT) @(negedge CLK);
         m_to = 1;
         m_bump();
         d_ok = 1;
         return;
      end
      repeat (ack_dly) @(negedge CLK);
      wr_ack_i = 1'b1;
      @(negedge CLK);
      wr_ack_i = 1'b0;
      d_drop = !wren_o;
      if (data_dly <= 0) begin
         for (int j = 2; j <= TIMEOUT + 1; j++) begin
            @(negedge CLK);
            if (j == TIMEOUT) d_b50 = busy;
            if (j == TIMEOUT + 1) d_b51 = busy;
         end
         m_to = 1;
         m_bump();
         d_ok = 1;
         return;
      end
      repeat (data_dly - 1) @(negedge CLK);
      do_valid_i = 1'b1;
      do_i = w;
      for (int k = 1; k <= 2; k++) begin
         @(negedge CLK);
         do_valid_i = 1'b0;
         do_i = 16'($urandom);
         if (current_valid) begin
            d_pulses++;
            if (d_lat < 0) d_lat = k;
         end
      end
      m_frame(w);
      d_ok = 1;
   endtask

   task automatic test_reset();
      enable = 1'b1;
      #1 reset = 1'b1;
      @(negedge CLK);
      vectors++;
      if ({wren_o, current_valid, overcurrent, status_err,
           timeout_err, busy} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b want 000000",
                  {wren_o, current_valid, overcurrent, status_err,
                   timeout_err, busy});
      end
      vectors++;
      if (current !== 13'sd0 || err_count !== 8'd0) begin
         miscompares++;
         $display("FAIL reset_values: current %0d err_count %0d want 0 0",
                  current, err_count);
      end
      reset = 1'b0;
      @(negedge CLK);
      vectors++;
      if (wren_o !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_req: wren_o %b busy %b want 1 1",
                  wren_o, busy);
      end
   endtask

   task automatic test_basic();
      txn(3, 2, 16'h1064);
      vectors++;
      if (!d_ok || !d_drop) begin
         miscompares++;
         $display("FAIL basic_handshake: ok %b wren_drop %b want 1 1",
                  d_ok, d_drop);
      end
      vectors++;
      if (d_pulses !== 1 || d_lat !== 2) begin
         miscompares++;
         $display("FAIL basic_valid: pulses %0d latency %0d want 1 2",
                  d_pulses, d_lat);
      end
      vectors++;
      if (int'(current) !== 100 || overcurrent !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_current: %0d oc %b want 100 0",
                  current, overcurrent);
      end
      @(negedge CLK);
      vectors++;
      if (current_valid !== 1'b0 || status_err !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_single_pulse: cv %b st %b want 0 0",
                  current_valid, status_err);
      end
   endtask

   task automatic test_bad_frames();
      txn(1, 1, 16'h8000);
      vectors++;
      if (status_err !== 1'b1 || int'(err_count) !== m_err ||
          int'(current) !== m_cur || d_pulses !== 0) begin
         miscompares++;
         $display("FAIL status_frame: st %b err %0d cur %0d pulses %0d want 1 %0d %0d 0",
                  status_err, err_count, current, d_pulses, m_err, m_cur);
      end
      txn(2, 3, 16'h1065);
      vectors++;
      if (status_err !== 1'b1 || int'(err_count) !== m_err ||
          int'(current) !== m_cur || d_pulses !== 0) begin
         miscompares++;
         $display("FAIL parity_frame: st %b err %0d cur %0d pulses %0d want 1 %0d %0d 0",
                  status_err, err_count, current, d_pulses, m_err, m_cur);
      end
   endtask

   task automatic pulse_clr();
      @(negedge CLK);
      err_clr = 1'b1;
      @(negedge CLK);
      err_clr = 1'b0;
      m_clear();
   endtask

   task automatic test_timeout();
      logic [15:0] w;
      pulse_clr();
      vectors++;
      if (err_count !== 8'd0 || status_err !== 1'b0 || timeout_err !== 1'b0) begin
         miscompares++;
         $display("FAIL err_clr: err %0d st %b to %b want 0 0 0",
                  err_count, status_err, timeout_err);
      end
      txn(0, 0, 16'h0);
      vectors++;
      if (d_b50 !== 1'b1 || d_b51 !== 1'b0) begin
         miscompares++;
         $display("FAIL wait_timeout_len: busy@50 %b busy@51 %b want 1 0",
                  d_b50, d_b51);
      end
      vectors++;
      if (timeout_err !== 1'b1 || int'(err_count) !== m_err) begin
         miscompares++;
         $display("FAIL wait_timeout_flag: to %b err %0d want 1 %0d",
                  timeout_err, err_count, m_err);
      end
      pulse_clr();
      w = 16'h1FFF ^ 16'h0000;
      if ($countones(w) % 2 == 1) w[14] = 1'b1;
      txn(4, TIMEOUT, w);
      vectors++;
      if (d_pulses !== 1 || timeout_err !== 1'b0 || err_count !== 8'd0 ||
          int'(current) !== m_cur) begin
         miscompares++;
         $display("FAIL wait_last_cycle: pulses %0d to %b err %0d cur %0d want 1 0 0 %0d",
                  d_pulses, timeout_err, err_count, current, m_cur);
      end
      txn(-1, 0, 16'h0);
      vectors++;
      if (!d_ok || busy !== 1'b0 || timeout_err !== 1'b1 ||
          int'(err_count) !== m_err) begin
         miscompares++;
         $display("FAIL req_timeout: ok %b busy %b to %b err %0d want 1 0 1 %0d",
                  d_ok, busy, timeout_err, err_count, m_err);
      end
   endtask

   task automatic test_long();
      int s0;
      pulse_clr();
      txn(TIMEOUT - 1, TIMEOUT, 16'h0000);
      s0 = d_start;
      vectors++;
      if (timeout_err !== 1'b0 || d_pulses !== 1 || int'(current) !== -4096) begin
         miscompares++;
         $display("FAIL long_txn: to %b pulses %0d cur %0d want 0 1 -4096",
                  timeout_err, d_pulses, current);
      end
      txn(0, 1, 16'h3FFF);
      vectors++;
      if (d_start - s0 !== 2 * TIMEOUT + 2) begin
         miscompares++;
         $display("FAIL long_spacing: got %0d want %0d",
                  d_start - s0, 2 * TIMEOUT + 2);
      end
   endtask

   task automatic test_random();
      logic [15:0] w;
      int prev = 0;
      int mode;
      for (int i = 0; i < 24; i++) begin
         w = 16'($urandom);
         if ($urandom_range(0, 4) == 0)
            w[12:0] = ($urandom_range(0, 1) == 1) ? 13'h1FFF : 13'h0000;
         mode = $urandom_range(0, 3);
         if (mode == 0) begin
            w[15] = 1'b1;
         end else if (mode == 1) begin
            w[15] = 1'b0;
            if ($countones(w) % 2 == 0) w[14] = ~w[14];
         end else begin
            w[15] = 1'b0;
            if ($countones(w) % 2 == 1) w[14] = ~w[14];
         end
         txn($urandom_range(0, 10), $urandom_range(1, 20), w);
         vectors++;
         if (!d_ok || d_pulses !== int'(good(w)) || int'(current) !== m_cur ||
             overcurrent !== m_oc || status_err !== m_st ||
             int'(err_count) !== m_err) begin
            miscompares++;
            $display("FAIL random_frame %0d w=%h: cur %0d oc %b st %b err %0d pulses %0d want %0d %b %b %0d %0d",
                     i, w, current, overcurrent, status_err, err_count,
                     d_pulses, m_cur, m_oc, m_st, m_err, int'(good(w)));
         end
         if (i > 0) begin
            vectors++;
            if (d_start - prev !== PERIOD) begin
               miscompares++;
               $display("FAIL period_spacing %0d: got %0d want %0d",
                        i, d_start - prev, PERIOD);
            end
         end
         prev = d_start;
      end
   endtask

   task automatic test_enable_ignore();
      int n = 0;
      int hits = 0;
      int cur0;
      bit st0;
      while (!wren_o && n < 3 * PERIOD) begin
         @(negedge CLK);
         n++;
      end
      enable = 1'b0;
      txn(2, 3, 16'h1064);
      vectors++;
      if (d_pulses !== 1 || int'(current) !== m_cur) begin
         miscompares++;
         $display("FAIL enable_low_completes: pulses %0d cur %0d want 1 %0d",
                  d_pulses, current, m_cur);
      end
      cur0 = int'(current);
      st0 = status_err;
      for (int i = 0; i < 150; i++) begin
         @(negedge CLK);
         if (wren_o || busy || current_valid) hits++;
         wr_ack_i = 1'($urandom);
         do_valid_i = 1'($urandom);
         do_i = 16'($urandom);
      end
      vectors++;
      if (hits !== 0 || int'(current) !== cur0 || status_err !== st0) begin
         miscompares++;
         $display("FAIL idle_ignore: activity %0d cur %0d st %b want 0 %0d %b",
                  hits, current, status_err, cur0, st0);
      end
      wr_ack_i = 1'b0;
      do_valid_i = 1'b0;
      enable = 1'b1;
      @(negedge CLK);
      vectors++;
      if (wren_o !== 1'b1) begin
         miscompares++;
         $display("FAIL enable_restart: wren_o %b want 1", wren_o);
      end
   endtask

   task automatic test_saturate();
      int n = 0;
      for (int i = 0; i < 300; i++) begin
         txn(0, 1, 16'h8000);
         if (i == 254) begin
            vectors++;
            if (int'(err_count) !== m_err) begin
               miscompares++;
               $display("FAIL err_count_255: got %0d want %0d",
                        err_count, m_err);
            end
         end
      end
      vectors++;
      if (err_count !== 8'd255 || m_err !== 255) begin
         miscompares++;
         $display("FAIL err_saturate: got %0d want 255", err_count);
      end
      while (!wren_o && n < 3 * PERIOD) begin
         @(negedge CLK);
         n++;
      end
      repeat (TIMEOUT - 1) @(negedge CLK);
      err_clr = 1'b1;
      @(negedge CLK);
      err_clr = 1'b0;
      m_clear();
      vectors++;
      if (busy !== 1'b0 || err_count !== 8'd0 || timeout_err !== 1'b0 ||
          status_err !== 1'b0) begin
         miscompares++;
         $display("FAIL clr_priority: busy %b err %0d to %b st %b want 0 0 0 0",
                  busy, err_count, timeout_err, status_err);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      while (!wren_o && n < 3 * PERIOD) begin
         @(negedge CLK);
         n++;
      end
      wr_ack_i = 1'b1;
      @(negedge CLK);
      wr_ack_i = 1'b0;
      do_valid_i = 1'b1;
      do_i = 16'h1064;
      #2 reset = 1'b1;
      #1;
      do_valid_i = 1'b0;
      m_cur = 0; m_oc = 0;
      m_clear();
      vectors++;
      if ({wren_o, busy, current_valid, overcurrent, status_err,
           timeout_err} !== 6'b0 || int'(current) !== m_cur ||
          int'(err_count) !== m_err) begin
         miscompares++;
         $display("FAIL reset_mid: flags %b cur %0d err %0d want 000000 0 0",
                  {wren_o, busy, current_valid, overcurrent, status_err,
                   timeout_err}, current, err_count);
      end
      @(negedge CLK);
      @(negedge CLK);
      vectors++;
      if (current_valid !== 1'b0 || int'(current) !== m_cur || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_hold: cv %b cur %0d busy %b want 0 0 0",
                  current_valid, current, busy);
      end
      reset = 1'b0;
      @(negedge CLK);
      vectors++;
      if (wren_o !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid_restart: wren_o %b want 1", wren_o);
      end
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_bad_frames();
      test_timeout();
      test_long();
      test_random();
      test_enable_ignore();
      test_saturate();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/current_sense_sequencer.md
CURRENT_SENSE_SEQUENCER -- requirements
Module: current_sense_sequencer

Interface
REQ-001 The block SHALL have parameter PERIOD, default 64000, meaning clock cycles between request starts (500 Hz at 32 MHz).
REQ-002 The block SHALL have parameter TIMEOUT, default 256, meaning the maximum cycles spent waiting in REQ or WAIT.
REQ-003 Port CLK  in  1  SHALL be the single system clock; all logic is on its rising edge.
REQ-004 Port reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-005 Port enable  in  1  SHALL, when high, allow new transactions to start.
REQ-006 Port err_clr  in  1  SHALL synchronously clear err_count, status_err and timeout_err.
REQ-007 Port wren_o  out  1  SHALL be the write-request to the SPI master.
REQ-008 Port wr_ack_i  in  1  SHALL be the SPI master write acknowledge.
REQ-009 Port do_valid_i  in  1  SHALL be the SPI master received-word strobe.
REQ-010 Port do_i  in  16  SHALL be the SPI master received word.
REQ-011 Port current  out  13 signed  SHALL be the last valid current sample (raw minus 4096).
REQ-012 Port current_valid  out  1  SHALL be a one-cycle pulse on each current update.
REQ-013 Port overcurrent  out  1  SHALL be do_i[13] of the last valid data frame.
REQ-014 Port status_err  out  1  SHALL be a sticky flag for a status frame or parity failure.
REQ-015 Port timeout_err  out  1  SHALL be a sticky flag for an ack or data timeout.
REQ-016 Port err_count  out  8  SHALL be a saturating count of all errors.
REQ-017 Port busy  out  1  SHALL be high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, REQ, WAIT, CHECK.
REQ-019 The period counter SHALL load PERIOD-1 on entry to REQ, decrement to 0, and hold at 0.
REQ-020 IDLE SHALL transition to REQ when enable=1 and the period counter=0.
REQ-021 In REQ, wren_o SHALL be high every cycle until wr_ack_i=1.
REQ-022 REQ SHALL transition to WAIT on wr_ack_i=1, with wren_o low in the next cycle.
REQ-023 WAIT SHALL latch do_i and go to CHECK on do_valid_i=1.
REQ-024 REQ and WAIT SHALL each go to IDLE after TIMEOUT cycles without their event, setting timeout_err and incrementing err_count.
REQ-025 If the event occurs in the same cycle as timeout expiry, the event SHALL win and no error is raised.
REQ-026 CHECK SHALL last one cycle and then return to IDLE.
REQ-027 In CHECK, a frame with bit15=1 SHALL be a status frame: set status_err, increment err_count, leave current unchanged.
REQ-028 In CHECK, a frame with bit15=0 SHALL fail parity when popcount(word[15:0]) is odd: set status_err, increment err_count, leave current unchanged.
REQ-029 In CHECK, a frame with bit15=0 and even parity SHALL update current <= {1'b0,word[12:0]} - 4096 (13-bit two's complement) and overcurrent <= word[13].
REQ-030 current_valid SHALL pulse in the cycle after CHECK, 2 cycles after do_valid_i.
REQ-031 Current range SHALL be -4096 (raw 0) to +4095 (raw 8191) with no saturation logic needed.
REQ-032 err_count SHALL saturate at 255 and not wrap.
REQ-033 err_clr SHALL take priority over a simultaneous error increment (the result is 0 and flags are clear).
REQ-034 enable going low mid-transaction SHALL let the transaction complete; IDLE then holds until enable=1.
REQ-035 do_valid_i or wr_ack_i asserted in IDLE or CHECK SHALL be ignored.
REQ-036 Request start spacing SHALL be exactly PERIOD cycles while enable=1 and each transaction completes in fewer than PERIOD cycles; otherwise the next start is the first IDLE cycle.

Reset
REQ-037 On reset assertion, the state SHALL become IDLE with the period counter=0.
REQ-038 On reset assertion, wren_o, current_valid, overcurrent, status_err, timeout_err and busy SHALL be 0.
REQ-039 On reset assertion, current SHALL be 0 and err_count SHALL be 0.
REQ-040 Reset asserted mid-transaction SHALL abort it with no partial update.
REQ-041 After reset release with enable=1, REQ SHALL be entered on the first clock edge.

Verification (bench PERIOD=100, TIMEOUT=50)
REQ-042 Bench: ack after 3 cycles, do_valid with do_i=0x1064 (parity even) -> current=+100, overcurrent=0, a single current_valid pulse.
REQ-043 Bench: do_i=0x8000 -> status_err=1, err_count=1, current unchanged.
REQ-044 Bench: do_i=0x1065 (odd parity) -> status_err=1, current unchanged.
REQ-045 Bench: no do_valid -> WAIT exits after 50 cycles, timeout_err=1; do_valid on cycle 50 -> accepted, no error.
REQ-046 Bench: continuous operation with enable=1 -> wren_o rising edges exactly 100 cycles apart.
REQ-047 Bench: 300 forced errors -> err_count=255; err_clr with a simultaneous error -> err_count=0; reset during WAIT -> idle outputs.
